// File: rtl/veer_trace_serializer.sv
// Splits VeeR retirement trace packets into per-slot records and drains them over valid/ready.
// Optional per-record cycle timestamp: define VEER_TRACE_TIMESTAMP_EN.
package veer_trace_pkg;
    typedef struct packed {
        logic [95:0] trace_rv_i_insn_ip;
        logic [95:0] trace_rv_i_address_ip;
        logic [2:0]  trace_rv_i_valid_ip;
        logic [2:0]  trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic [2:0]  trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } trace_pkt_t;
endpackage

module veer_trace_serializer
    import veer_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  trace_pkt_t               trace_pkt,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [31:0]              trc_insn,
    output logic [31:0]              trc_addr,
    output logic [1:0]               trc_slot,
    output logic                     trc_exception,
    output logic                     trc_interrupt,
    output logic [4:0]               trc_ecause,
    output logic [31:0]              trc_tval,
    output logic                     trc_ovf,
`ifdef VEER_TRACE_TIMESTAMP_EN
    output logic [31:0]              trc_tstamp,
`endif
    output logic [CNTW-1:0]          drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic [1:0]  slot;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic        ovf;
`ifdef VEER_TRACE_TIMESTAMP_EN
        logic [31:0] tstamp;
`endif
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          slot_rec [3];
    logic [1:0]    slot_off [3];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] level;
    logic [LW-1:0] space;
    logic          ovf_pend;
    logic [2:0]    vld;
    logic [1:0]    n;
    logic          accept;
    logic          pop;
    rec_t          head;
`ifdef VEER_TRACE_TIMESTAMP_EN
    logic [31:0]   cycle_cnt;
`endif

    assign vld    = trace_pkt.trace_rv_i_valid_ip;
    assign n      = 2'(vld[0]) + 2'(vld[1]) + 2'(vld[2]);
    assign space  = LW'(DEPTH) - level;
    assign accept = (n != 2'd0) && (space >= LW'(n));
    assign pop    = trc_valid && trc_ready;

    // Valid slots are packed densely in ascending slot order.
    always_comb begin
        slot_off[0] = 2'd0;
        slot_off[1] = 2'(vld[0]);
        slot_off[2] = 2'(vld[0]) + 2'(vld[1]);
        for (int k = 0; k < 3; k++) begin
            slot_rec[k].insn   = trace_pkt.trace_rv_i_insn_ip[32*k +: 32];
            slot_rec[k].addr   = trace_pkt.trace_rv_i_address_ip[32*k +: 32];
            slot_rec[k].slot   = 2'(k);
            slot_rec[k].exc    = trace_pkt.trace_rv_i_exception_ip[k];
            slot_rec[k].intr   = trace_pkt.trace_rv_i_interrupt_ip[k];
            slot_rec[k].ecause = (slot_rec[k].exc || slot_rec[k].intr)
                               ? trace_pkt.trace_rv_i_ecause_ip : 5'd0;
            slot_rec[k].tval   = (slot_rec[k].exc || slot_rec[k].intr)
                               ? trace_pkt.trace_rv_i_tval_ip : 32'd0;
            slot_rec[k].ovf    = ovf_pend && (slot_off[k] == 2'd0);
`ifdef VEER_TRACE_TIMESTAMP_EN
            slot_rec[k].tstamp = cycle_cnt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) mem[wptr + AW'(slot_off[k])] <= slot_rec[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            drop_cnt <= '0;
            ovf_pend <= 1'b0;
        end else begin
            if (accept) begin
                wptr     <= wptr + AW'(n);
                ovf_pend <= 1'b0;
            end else if (n != 2'd0) begin
                ovf_pend <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNTW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            level <= level + (accept ? LW'(n) : LW'(0)) - LW'(pop);
        end
    end

`ifdef VEER_TRACE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    assign head          = mem[rptr];
    assign trc_valid     = (level != '0) && !rst;
    assign trc_insn      = head.insn;
    assign trc_addr      = head.addr;
    assign trc_slot      = head.slot;
    assign trc_exception = head.exc;
    assign trc_interrupt = head.intr;
    assign trc_ecause    = head.ecause;
    assign trc_tval      = head.tval;
    assign trc_ovf       = head.ovf;
`ifdef VEER_TRACE_TIMESTAMP_EN
    assign trc_tstamp    = head.tstamp;
`endif
    assign fifo_level    = level;
endmodule
